// File: rtl/xt_enc_pkg.sv
// Shared types and default geometry for the crosstalk-aware bus encoder.
package xt_enc_pkg;

   typedef enum logic [1:0] {
      XT_BYPASS = 2'b00,
      XT_BINV   = 2'b01,
      XT_XTALK  = 2'b10
   } xt_mode_e;

   localparam int unsigned SEG_W_DEF = 16;
   localparam int unsigned NSEG_DEF  = 2;
   localparam int unsigned CNT_W_DEF = 16;

endpackage

// File: rtl/xt_seg_dec.sv
// Per-segment invert decision: compares the candidate word against the word currently on the bus.
module xt_seg_dec
   import xt_enc_pkg::*;
#(
   parameter int unsigned PW = SEG_W_DEF - 1
) (
   input  logic [PW-1:0] prev,
   input  logic [PW-1:0] cur,
   input  logic [1:0]    mode,
   output logic          inv
);

   function automatic int unsigned popcnt(input logic [PW-1:0] v);
      int unsigned n;
      n = 0;
      for (int unsigned i = 0; i < PW; i++) begin
         if (v[i]) n++;
      end
      return n;
   endfunction

   // Adjacent line pairs that toggle in opposite directions going prev -> c.
   function automatic int unsigned xt_cost(input logic [PW-1:0] p, input logic [PW-1:0] c);
      logic [PW-1:0] up;
      logic [PW-1:0] dn;
      int unsigned   n;
      up = ~p & c;
      dn = p & ~c;
      n  = 0;
      for (int unsigned i = 0; i + 1 < PW; i++) begin
         if ((up[i] && dn[i+1]) || (dn[i] && up[i+1])) n++;
      end
      return n;
   endfunction

   always_comb begin
      inv = 1'b0;
      case (mode)
         XT_BINV:  inv = (popcnt(prev ^ cur) << 1) > PW;
         XT_XTALK: inv = xt_cost(prev, cur) > xt_cost(prev, ~cur);
         default:  inv = 1'b0;
      endcase
   end

endmodule

// File: rtl/xt_bus_encoder.sv
// Two-stage bus encoder: stage A captures payload+mode, stage B drives the encoded bus.
module xt_bus_encoder
   import xt_enc_pkg::*;
#(
   parameter int unsigned SEG_W = SEG_W_DEF,
   parameter int unsigned NSEG  = NSEG_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [1:0]                mode,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [NSEG*(SEG_W-1)-1:0] in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [NSEG*SEG_W-1:0]     out_data,
   input  logic                      cnt_clr,
   output logic [NSEG*CNT_W-1:0]     inv_cnt
);

   localparam int unsigned PW = SEG_W - 1;

   logic                    a_valid_q;
   logic [NSEG*PW-1:0]      a_data_q;
   logic [1:0]              a_mode_q;
   logic                    out_valid_q;
   logic [NSEG*SEG_W-1:0]   out_data_q;
   logic [NSEG*CNT_W-1:0]   cnt_q, cnt_d;
   logic [NSEG*SEG_W-1:0]   enc_d;
   logic [NSEG-1:0]         seg_inv;
   logic                    b_adv;
   logic                    accept;

   assign b_adv    = a_valid_q && (!out_valid_q || out_ready);
   assign in_ready = !a_valid_q || b_adv;
   assign accept   = in_valid && in_ready;

   for (genvar k = 0; k < NSEG; k++) begin : g_seg
      // Reference is the payload currently on the bus, flag line excluded.
      xt_seg_dec #(
         .PW (PW)
      ) u_dec (
         .prev (out_data_q[k*SEG_W +: PW]),
         .cur  (a_data_q[k*PW +: PW]),
         .mode (a_mode_q),
         .inv  (seg_inv[k])
      );

      assign enc_d[k*SEG_W +: SEG_W] =
         {seg_inv[k], seg_inv[k] ? ~a_data_q[k*PW +: PW] : a_data_q[k*PW +: PW]};
   end

   always_comb begin
      cnt_d = cnt_q;
      for (int unsigned k = 0; k < NSEG; k++) begin
         if (cnt_clr) begin
            cnt_d[k*CNT_W +: CNT_W] = '0;
         end else if (b_adv && seg_inv[k] && (cnt_q[k*CNT_W +: CNT_W] != '1)) begin
            cnt_d[k*CNT_W +: CNT_W] = cnt_q[k*CNT_W +: CNT_W] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_valid_q   <= 1'b0;
         a_data_q    <= '0;
         a_mode_q    <= 2'b00;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         cnt_q       <= '0;
      end else begin
         if (accept) begin
            a_valid_q <= 1'b1;
            a_data_q  <= in_data;
            a_mode_q  <= mode;
         end else if (b_adv) begin
            a_valid_q <= 1'b0;
         end

         if (b_adv) begin
            out_valid_q <= 1'b1;
            out_data_q  <= enc_d;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end

         cnt_q <= cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign inv_cnt   = cnt_q;

endmodule

// File: tb/tb_xt_bus_encoder.sv
// Directed bench for xt_bus_encoder: vector table plus backpressure, saturation and reset sequences.
module tb_xt_bus_encoder;

   localparam int unsigned SEG_W = 16;
   localparam int unsigned NSEG  = 2;
   localparam int unsigned CNT_W = 4;

   logic        clk;
   logic        rst_n;
   logic [1:0]  mode;
   logic        in_valid;
   logic        in_ready;
   logic [29:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        cnt_clr;
   logic [7:0]  inv_cnt;

   int errors;
   int checks;

   xt_bus_encoder #(
      .SEG_W (SEG_W),
      .NSEG  (NSEG),
      .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .cnt_clr   (cnt_clr),
      .inv_cnt   (inv_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  mode;
      logic [14:0] s1;
      logic [14:0] s0;
      logic [31:0] exp_out;
      logic [7:0]  exp_cnt;
   } vec_t;

   vec_t vecs[9];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic offer(input logic [1:0] m, input logic [14:0] s1, input logic [14:0] s0);
      mode     = m;
      in_data  = {s1, s0};
      in_valid = 1'b1;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      // {mode, seg1, seg0, expected out_data, expected {cnt1,cnt0}}
      vecs[0] = '{2'b01, 15'h0000, 15'h7FFF, 32'h0000_8000, 8'h01};
      vecs[1] = '{2'b01, 15'h0000, 15'h0000, 32'h0000_0000, 8'h01};
      vecs[2] = '{2'b00, 15'h7FFF, 15'h7FFF, 32'h7FFF_7FFF, 8'h01};
      vecs[3] = '{2'b01, 15'h7F00, 15'h7F80, 32'h80FF_7F80, 8'h11};
      vecs[4] = '{2'b11, 15'h7FFF, 15'h0000, 32'h7FFF_0000, 8'h11};
      vecs[5] = '{2'b00, 15'h0000, 15'h5555, 32'h0000_5555, 8'h11};
      vecs[6] = '{2'b10, 15'h0001, 15'h2AAA, 32'h0001_D555, 8'h12};
      vecs[7] = '{2'b10, 15'h0002, 15'h5555, 32'hFFFD_5555, 8'h22};
      vecs[8] = '{2'b01, 15'h7FFD, 15'h55AA, 32'h7FFD_AA55, 8'h23};

      rst_n     = 1'b0;
      mode      = 2'b00;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      cnt_clr   = 1'b0;
      #12;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_inv_cnt", {24'd0, inv_cnt}, 32'd0);
      rst_n = 1'b1;
      step();
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

      for (int i = 0; i < 9; i++) begin
         offer(vecs[i].mode, vecs[i].s1, vecs[i].s0);
         step();
         in_valid = 1'b0;
         step();
         chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].exp_out);
         chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
         chk($sformatf("vec%0d_inv_cnt", i), {24'd0, inv_cnt}, {24'd0, vecs[i].exp_cnt});
      end

      // Backpressure: B stalls, A fills, third word must wait.
      step();
      chk("bp_drained", {31'd0, out_valid}, 32'd0);
      out_ready = 1'b0;
      offer(2'b00, 15'h0123, 15'h0456);
      chk("bp_rdy0", {31'd0, in_ready}, 32'd1);
      step();
      offer(2'b00, 15'h1111, 15'h2222);
      chk("bp_rdy1", {31'd0, in_ready}, 32'd1);
      step();
      offer(2'b00, 15'h3333, 15'h0444);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("bp_stall%0d_rdy", i), {31'd0, in_ready}, 32'd0);
         chk($sformatf("bp_stall%0d_data", i), out_data, 32'h0123_0456);
         chk($sformatf("bp_stall%0d_valid", i), {31'd0, out_valid}, 32'd1);
         step();
      end
      chk("bp_hold_data", out_data, 32'h0123_0456);
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      chk("bp_w1", out_data, 32'h1111_2222);
      chk("bp_w1_valid", {31'd0, out_valid}, 32'd1);
      step();
      chk("bp_w2", out_data, 32'h3333_0444);
      chk("bp_w2_valid", {31'd0, out_valid}, 32'd1);
      step();
      chk("bp_empty", {31'd0, out_valid}, 32'd0);

      // Saturation: zero the reference, then stream back-to-back inverting words.
      offer(2'b00, 15'h0000, 15'h0000);
      step();
      offer(2'b01, 15'h7FFF, 15'h7FFF);
      for (int i = 0; i < 20; i++) step();
      chk("sat_in_ready", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
      step();
      step();
      chk("sat_inv_cnt", {24'd0, inv_cnt}, 32'h0000_00FF);
      chk("sat_out_data", out_data, 32'h8000_8000);

      // Clear wins over a same-cycle increment.
      offer(2'b01, 15'h7FFF, 15'h7FFF);
      step();
      in_valid = 1'b0;
      cnt_clr  = 1'b1;
      step();
      cnt_clr  = 1'b0;
      chk("clr_inv_cnt", {24'd0, inv_cnt}, 32'd0);
      chk("clr_out_data", out_data, 32'h8000_8000);
      offer(2'b01, 15'h7FFF, 15'h7FFF);
      step();
      in_valid = 1'b0;
      step();
      chk("clr_resume_cnt", {24'd0, inv_cnt}, 32'h0000_0011);

      // Reset with both stages full: nothing may be emitted afterwards.
      out_ready = 1'b0;
      offer(2'b00, 15'h1234, 15'h0567);
      step();
      offer(2'b00, 15'h0ABC, 15'h0DEF);
      step();
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_data", out_data, 32'd0);
      chk("mid_rst_cnt", {24'd0, inv_cnt}, 32'd0);
      step();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      step();
      chk("mid_rst_rdy", {31'd0, in_ready}, 32'd1);
      chk("mid_rst_novalid", {31'd0, out_valid}, 32'd0);
      step();
      chk("mid_rst_discard", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_data2", out_data, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/xt_bus_encoder.md
XT_BUS_ENCODER -- requirements
Module: xt_bus_encoder

Interface
REQ-001 Parameter SEG_W, default 16, segment width on the bus: SEG_W-1 payload lines plus 1 invert-flag line at the segment MSB.
REQ-002 Parameter NSEG, default 2, number of independently encoded segments.
REQ-003 Parameter CNT_W, default 16, width of each per-segment inversion counter.
REQ-004 Clocking SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 mode  in  2  00 bypass, 01 bus-invert, 10 crosstalk-invert, 11 treated as bypass.
REQ-008 in_valid  in  1  in_data offered.
REQ-009 in_ready  out  1  stage A can accept.
REQ-010 in_data  in  NSEG*(SEG_W-1)  payload; segment k occupies bits k*(SEG_W-1) upward.
REQ-011 out_valid  out  1  out_data holds an undelivered word.
REQ-012 out_ready  in  1  downstream accepts.
REQ-013 out_data  out  NSEG*SEG_W  encoded bus; segment k = {inv_k, payload_k or ~payload_k}.
REQ-014 cnt_clr  in  1  synchronous clear of all inversion counters.
REQ-015 inv_cnt  out  NSEG*CNT_W  per-segment count of inverted words delivered.

Function
REQ-016 Two registered stages: A captures {in_data, mode} on in_valid&&in_ready; B holds out_data/out_valid.
REQ-017 B advances when A is valid and (!out_valid || out_ready); in_ready = !a_valid || B advances.
REQ-018 Latency: word accepted at edge N SHALL appear on out_data with out_valid at edge N+1 when unstalled; full throughput one word/cycle.
REQ-019 out_data and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-020 Reference word for segment k decisions = current out_data payload lines of segment k (last presented word, flag excluded).
REQ-021 Bus-invert: H = Hamming distance(prev, new); invert iff 2*H > SEG_W-1.
REQ-022 Crosstalk-invert: cost(c) = number of adjacent line pairs (i,i+1) where both lines toggle prev->c in opposite directions; invert iff cost(new) > cost(~new).
REQ-023 Ties SHALL not invert; bypass SHALL never invert.
REQ-024 Each segment decides independently, using the mode captured with that word in stage A.
REQ-025 inv_cnt[k] SHALL increment by 1 for each word whose inv_k=1 is loaded into B, saturating at all-ones.
REQ-026 cnt_clr takes priority over a same-cycle increment; result is 0.

Reset
REQ-027 rst_n low: a_valid=0, out_valid=0, out_data=0, inv_cnt=0; in_ready=1 from first edge after release.
REQ-028 Reset mid-transfer SHALL discard words in A and B without emitting them.

Structure
REQ-029 Package xt_enc_pkg SHALL hold the mode enum (XT_BYPASS, XT_BINV, XT_XTALK) and default SEG_W/NSEG constants.
REQ-030 Per-segment decision logic SHALL be a combinational sub-module xt_seg_dec (prev, new, mode -> inv), instantiated NSEG times.

Verification (SEG_W=16, NSEG=2)
REQ-031 Reset: assert rst_n=0 mid-stream -> out_valid=0, out_data=0, inv_cnt=0, in_ready=1 after release.
REQ-032 Bus-invert: prev 0, seg0 payload 15'h7FFF -> seg0 out {1,15'h0000}; then 15'h0000 -> {0,15'h0000}.
REQ-033 Crosstalk: seg0 prev 15'h5555 (flag 0), new 15'h2AAA -> cost 14 vs 0 -> out {1,15'h5555}; inv_cnt[0] increments.
REQ-034 Backpressure: out_ready=0 for 3 cycles, 3 words offered -> 2 accepted, in_ready=0, out_data stable; release -> words in order, none lost.
REQ-035 Bypass/tie: mode 00 with 15'h7FFF -> flag 0; bus-invert with H=7 -> flag 0.
REQ-036 Counter: preload to CNT_W all-ones by forcing inversions -> stays saturated; cnt_clr with simultaneous inversion -> 0.
